rx_byte_assembler: RTL

- Stage directly downstream of the sync detector (circuito12).
- Once the detector flags a valid SYNC on the k/j line, this block:
  - NRZI-decodes subsequent line samples;
  - strips stuffed bits;
  - assembles bits LSB-first into bytes;
  - detects end-of-packet (EOP).
- Produces a byte stream with per-byte valid strobe plus error/EOP pulses for the packet layer.

---
 rtl/rx_byte_assembler_pkg.sv | 27 ++
 rtl/rx_byte_assembler_if.sv | 31 +++
 rtl/rx_byte_assembler_nrzi_destuff.sv | 60 ++++++
 rtl/rx_byte_assembler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rx_byte_assembler_pkg.sv
// Shared types and defaults for the receive byte assembler: line-state
// encoding ({k, j}), FSM states and default widths/lengths.
package rx_byte_assembler_pkg;

   localparam int DATA_W_DEF    = 8;
   localparam int STUFF_LEN_DEF = 6;
   localparam int EOP_SE0_DEF   = 2;

   typedef enum logic [1:0] {
      LS_SE0 = 2'b00,
      LS_J   = 2'b01,
      LS_K   = 2'b10,
      LS_ILL = 2'b11
   } line_state_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_EOP,
      ST_ERR
   } state_t;

   function automatic line_state_t line_decode(input logic k, input logic j);
      return line_state_t'({k, j});
   endfunction

endpackage

// File: rtl/rx_byte_assembler_if.sv
// Line-side inputs and byte/status outputs of the receive byte assembler.
interface rx_byte_assembler_if
   import rx_byte_assembler_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              k;
   logic              j;
   logic              rx_en;
   logic              synced;
   logic              sync_err;
   logic [DATA_W-1:0] data;
   logic              data_valid;
   logic              eop;
   logic              align_err;
   logic              stuff_err;
   logic              line_err;
   logic              active;

   modport master (
      output k, j, rx_en, synced, sync_err,
      input  data, data_valid, eop, align_err, stuff_err, line_err, active
   );

   modport slave (
      input  k, j, rx_en, synced, sync_err,
      output data, data_valid, eop, align_err, stuff_err, line_err, active
   );

endinterface

// File: rtl/rx_byte_assembler_nrzi_destuff.sv
// NRZI decoder and bit de-stuffer: classifies each qualified line sample and
// tracks the previous J/K level and the run of decoded ones.
module rx_byte_assembler_nrzi_destuff
   import rx_byte_assembler_pkg::*;
#(
   parameter int STUFF_LEN = STUFF_LEN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic k,
   input  logic j,
   input  logic rx_en,
   input  logic load,
   output logic dec_bit,
   output logic bit_valid,
   output logic stuffed,
   output logic stuff_violation,
   output logic se0,
   output logic ill
);

   localparam int ONES_W = $clog2(STUFF_LEN + 1);

   line_state_t       line;
   line_state_t       prev_line;
   logic [ONES_W-1:0] ones_cnt;
   logic              is_jk;
   logic              at_limit;

   always_comb begin
      line            = line_decode(k, j);
      is_jk           = rx_en && ((line == LS_J) || (line == LS_K));
      at_limit        = (ones_cnt == ONES_W'(STUFF_LEN));
      dec_bit         = (line == prev_line);
      bit_valid       = is_jk && !at_limit;
      stuffed         = is_jk && at_limit && !dec_bit;
      stuff_violation = is_jk && at_limit && dec_bit;
      se0             = rx_en && (line == LS_SE0);
      ill             = rx_en && (line == LS_ILL);
   end

   // ones_cnt never passes STUFF_LEN: at the limit only a stuffed 0 or a violation can follow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_line <= LS_K;
         ones_cnt  <= '0;
      end else if (load) begin
         prev_line <= LS_K;
         ones_cnt  <= '0;
      end else if (is_jk) begin
         prev_line <= line;
         if (stuffed) begin
            ones_cnt <= '0;
         end else if (bit_valid) begin
            ones_cnt <= dec_bit ? ones_cnt + ONES_W'(1) : '0;
         end
      end
   end

endmodule

// File: rtl/rx_byte_assembler.sv
// Receive byte assembler: after SYNC, collects de-stuffed NRZI bits LSB-first
// into words and recognises the SE0..SE0,J end-of-packet.
module rx_byte_assembler
   import rx_byte_assembler_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int STUFF_LEN = STUFF_LEN_DEF,
   parameter int EOP_SE0   = EOP_SE0_DEF
) (
   input logic               clk,
   input logic               rst,
   rx_byte_assembler_if.slave bus
);

   // state   | meaning
   // IDLE    | waiting for synced, line ignored
   // RECV    | decoding bits into the shift register
   // EOP     | counting SE0 samples, expecting a final J
   // ERR     | one-cycle recovery after a fault, then IDLE

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int SE0_W = $clog2(EOP_SE0 + 1);

   state_t            state;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] word_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [IDX_W-1:0]  bit_idx;
   logic [SE0_W-1:0]  se0_left;

   logic [DATA_W-1:0] data_q;
   logic              data_valid_q;
   logic              eop_q;
   logic              align_err_q;
   logic              stuff_err_q;
   logic              line_err_q;
   logic              active_q;

   logic dec_bit;
   logic bit_valid;
   logic stuffed;
   logic stuff_violation;
   logic se0;
   logic ill;
   logic jk_sample;
   logic load;

   assign load = (state == ST_IDLE) && bus.synced && !bus.sync_err;

   rx_byte_assembler_nrzi_destuff #(
      .STUFF_LEN (STUFF_LEN)
   ) u_nrzi_destuff (
      .clk             (clk),
      .rst             (rst),
      .k               (bus.k),
      .j               (bus.j),
      .rx_en           (bus.rx_en),
      .load            (load),
      .dec_bit         (dec_bit),
      .bit_valid       (bit_valid),
      .stuffed         (stuffed),
      .stuff_violation (stuff_violation),
      .se0             (se0),
      .ill             (ill)
   );

   always_comb begin
      jk_sample         = bit_valid || stuffed || stuff_violation;
      bit_idx           = bit_cnt[IDX_W-1:0];
      word_nxt          = shift_reg;
      word_nxt[bit_idx] = dec_bit;
   end

   // se0_left counts down the SE0 samples still required before the closing J.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         se0_left     <= '0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         eop_q        <= 1'b0;
         align_err_q  <= 1'b0;
         stuff_err_q  <= 1'b0;
         line_err_q   <= 1'b0;
         active_q     <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;
         eop_q        <= 1'b0;
         align_err_q  <= 1'b0;
         stuff_err_q  <= 1'b0;
         line_err_q   <= 1'b0;
         if (bus.sync_err) begin
            state    <= ST_IDLE;
            active_q <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (bus.synced) begin
                     state     <= ST_RECV;
                     active_q  <= 1'b1;
                     bit_cnt   <= '0;
                     shift_reg <= '0;
                  end
               end
               ST_RECV: begin
                  if (stuff_violation) begin
                     stuff_err_q <= 1'b1;
                     state       <= ST_ERR;
                     active_q    <= 1'b0;
                  end else if (bit_valid) begin
                     if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        data_q       <= word_nxt;
                        data_valid_q <= 1'b1;
                        bit_cnt      <= '0;
                     end else begin
                        shift_reg <= word_nxt;
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                     end
                  end else if (se0) begin
                     state    <= ST_EOP;
                     se0_left <= SE0_W'(EOP_SE0 - 1);
                  end else if (ill) begin
                     line_err_q <= 1'b1;
                     state      <= ST_ERR;
                     active_q   <= 1'b0;
                  end
               end
               ST_EOP: begin
                  if (se0 && (se0_left != '0)) begin
                     se0_left <= se0_left - SE0_W'(1);
                  end else if (jk_sample && bus.j && (se0_left == '0)) begin
                     eop_q       <= 1'b1;
                     align_err_q <= (bit_cnt != '0);
                     state       <= ST_IDLE;
                     active_q    <= 1'b0;
                  end else if (bus.rx_en) begin
                     line_err_q <= 1'b1;
                     state      <= ST_ERR;
                     active_q   <= 1'b0;
                  end
               end
               ST_ERR: begin
                  state    <= ST_IDLE;
                  active_q <= 1'b0;
               end
               default: begin
                  state    <= ST_IDLE;
                  active_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.data       = data_q;
   assign bus.data_valid = data_valid_q;
   assign bus.eop        = eop_q;
   assign bus.align_err  = align_err_q;
   assign bus.stuff_err  = stuff_err_q;
   assign bus.line_err   = line_err_q;
   assign bus.active     = active_q;

endmodule
